mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 28, memory block address width.
REQ-002 SHALL have parameter DATA_W, 128, memory block data width.
REQ-003 SHALL have one clock and an asynchronous active-low reset, as the following two ports.
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ic_mem_read  input  1  I-cache read request, held until ic_mem_ready.
REQ-007 SHALL have port ic_mem_addr  input  ADDR_W  I-cache block address.
REQ-008 SHALL have port ic_mem_rdata  output  DATA_W  read data to I-cache.
REQ-009 SHALL have port ic_mem_ready  output  1  one-cycle completion pulse to I-cache.
REQ-010 SHALL have port dc_mem_read  input  1  D-cache read request, held until dc_mem_ready.
REQ-011 SHALL have port dc_mem_write  input  1  D-cache write request, held until dc_mem_ready.
REQ-012 SHALL have port dc_mem_addr  input  ADDR_W  D-cache block address.
REQ-013 SHALL have port dc_mem_wdata  input  DATA_W  D-cache write block.
REQ-014 SHALL have port dc_mem_rdata  output  DATA_W  read data to D-cache.
REQ-015 SHALL have port dc_mem_ready  output  1  one-cycle completion pulse to D-cache.
REQ-016 SHALL have ports mem_read, mem_write  output  1 each  request to shared memory.
REQ-017 SHALL have ports mem_addr  output  ADDR_W and mem_wdata  output  DATA_W  to memory.
REQ-018 SHALL have ports mem_rdata  input  DATA_W and mem_ready  input  1  from memory.
REQ-019 SHALL have ports ic_wait_cnt, dc_wait_cnt  output  16 each  stall-cycle counters.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY, RELEASE; owner register (I/D) and last_grant register (I/D).
REQ-021 IDLE: no request -> stay; one requester pending -> grant it; both pending -> grant the one not equal to last_grant (round-robin).
REQ-022 On grant SHALL latch command, address, wdata of the winner into registers, set owner and last_grant, go to BUSY next cycle.
REQ-023 D-side with dc_mem_read and dc_mem_write both high SHALL be latched as a write; read ignored.
REQ-024 mem_read/mem_write/mem_addr/mem_wdata SHALL be driven only from latched registers, and only in BUSY; mem_read=mem_write=0 in IDLE and RELEASE.
REQ-025 Latency: request high in IDLE cycle N -> memory command visible in cycle N+1.
REQ-026 BUSY: stay until mem_ready=1; in that cycle owner's xx_mem_ready=1 (combinational) and xx_mem_rdata=mem_rdata; next state RELEASE.
REQ-027 Non-owner ready SHALL be 0 always; both rdata outputs MAY pass mem_rdata unconditionally.
REQ-028 RELEASE SHALL last exactly one cycle, always -> IDLE, allowing the served requester to drop its request before re-arbitration.
REQ-029 Minimum back-to-back spacing: mem_ready in cycle M -> next memory command no earlier than cycle M+3.
REQ-030 Requester dropping its request during BUSY SHALL NOT abort the transaction; ready still pulsed on completion.
REQ-031 mem_ready in IDLE or RELEASE SHALL be ignored (no ready pulse, no state change).
REQ-032 xx_wait_cnt SHALL increment each cycle its request is high and its ready is 0; saturate at 16'hFFFF; never wrap.

Reset
REQ-033 rst low SHALL asynchronously force state IDLE, owner=I, last_grant=I, latched regs 0, wait counters 0.
REQ-034 During reset all outputs SHALL be 0; reset in BUSY SHALL abandon the transaction with no ready pulse.
REQ-035 First arbitration after reset with both pending SHALL grant D (last_grant=I).

Verification
REQ-036 Single I read addr 28'h10, memory ready after 4 cycles, rdata 128'hA5 -> mem_read=1 cycles 1-4, ic_mem_ready=1 cycle 4 with rdata 128'hA5, dc_mem_ready never 1.
REQ-037 Both request at reset release -> D served first, I served second; ic_wait_cnt equals cycles I was pending unserved.
REQ-038 D holds read+write high, addr 28'h20, wdata 128'h1 -> mem_write=1, mem_read=0, mem_addr 28'h20.
REQ-039 Continuous I and D requests for 6 transactions -> grants alternate D,I,D,I,D,I; memory idle exactly 2 cycles between commands.
REQ-040 Stray mem_ready in IDLE -> no ready pulse; rst asserted mid-BUSY -> mem_read/mem_write 0 immediately, counters 0.
REQ-041 D request held with memory never ready for 70000 cycles -> dc_wait_cnt stops at 16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared bus bundle between the two cache requesters, the arbiter and the memory.
// The arbiter binds the slave view; the surrounding system drives the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              ic_mem_read;
  logic [ADDR_W-1:0] ic_mem_addr;
  logic [DATA_W-1:0] ic_mem_rdata;
  logic              ic_mem_ready;

  logic              dc_mem_read;
  logic              dc_mem_write;
  logic [ADDR_W-1:0] dc_mem_addr;
  logic [DATA_W-1:0] dc_mem_wdata;
  logic [DATA_W-1:0] dc_mem_rdata;
  logic              dc_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  ic_mem_read, ic_mem_addr,
    input  dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata,
    input  mem_rdata, mem_ready,
    output ic_mem_rdata, ic_mem_ready,
    output dc_mem_rdata, dc_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output ic_mem_read, ic_mem_addr,
    output dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata,
    output mem_rdata, mem_ready,
    input  ic_mem_rdata, ic_mem_ready,
    input  dc_mem_rdata, dc_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block memory port between I-cache and D-cache.
// One transaction at a time: IDLE grants, BUSY waits for mem_ready, RELEASE lets the winner drop.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus,
  output logic [15:0]      ic_wait_cnt,
  output logic [15:0]      dc_wait_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t            state;
  logic              owner_d;
  logic              last_d;
  logic              cmd_wr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic ic_req;
  logic dc_req;
  logic grant_d;
  logic busy;
  logic done;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign ic_req  = bus.ic_mem_read;
  assign dc_req  = bus.dc_mem_read | bus.dc_mem_write;
  // Contention goes to whoever did not win last time; a lone requester always wins.
  assign grant_d = dc_req & (~ic_req | ~last_d);

  // Stage p0: latch the winner's command at grant time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      last_d    <= 1'b0;
      cmd_wr_p0 <= 1'b0;
      addr_p0   <= '0;
      wdata_p0  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ic_req | dc_req) begin
            state   <= BUSY;
            owner_d <= grant_d;
            last_d  <= grant_d;
            if (grant_d) begin
              cmd_wr_p0 <= bus.dc_mem_write;
              addr_p0   <= bus.dc_mem_addr;
              wdata_p0  <= bus.dc_mem_wdata;
            end else begin
              cmd_wr_p0 <= 1'b0;
              addr_p0   <= bus.ic_mem_addr;
              wdata_p0  <= '0;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ready) state <= RELEASE;
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side is driven only while a latched transaction is in flight.
  assign busy          = (state == BUSY);
  assign done          = busy & bus.mem_ready;
  assign bus.mem_read  = busy & ~cmd_wr_p0;
  assign bus.mem_write = busy &  cmd_wr_p0;
  assign bus.mem_addr  = busy ? addr_p0  : '0;
  assign bus.mem_wdata = busy ? wdata_p0 : '0;

  assign bus.ic_mem_ready = done & ~owner_d;
  assign bus.dc_mem_ready = done &  owner_d;
  assign bus.ic_mem_rdata = bus.ic_mem_ready ? bus.mem_rdata : '0;
  assign bus.dc_mem_rdata = bus.dc_mem_ready ? bus.mem_rdata : '0;

  // Stall counters: a pending request not completing this cycle costs one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic_wait_cnt <= '0;
      dc_wait_cnt <= '0;
    end else begin
      if (ic_req & ~bus.ic_mem_ready) ic_wait_cnt <= sat_inc(ic_wait_cnt);
      if (dc_req & ~bus.dc_mem_ready) dc_wait_cnt <= sat_inc(dc_wait_cnt);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, round-robin, write priority,
// stray ready, mid-transaction reset and stall-counter saturation.
module tb_mem_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ic_wait_cnt;
  logic [15:0] dc_wait_cnt;
  int          tests  = 0;
  int          failed = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .ic_wait_cnt (ic_wait_cnt),
    .dc_wait_cnt (dc_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int idle;
    bus.ic_mem_read  = 1'b0;
    bus.ic_mem_addr  = '0;
    bus.dc_mem_read  = 1'b0;
    bus.dc_mem_write = 1'b0;
    bus.dc_mem_addr  = '0;
    bus.dc_mem_wdata = '0;
    bus.mem_rdata    = '0;
    bus.mem_ready    = 1'b0;

    // Reset holds everything quiet even with a request present
    tick(); tick();
    bus.ic_mem_read = 1'b1;
    bus.mem_ready   = 1'b1;
    #1;
    chk("rst_mem_read",  128'(bus.mem_read),     128'(0));
    chk("rst_mem_write", 128'(bus.mem_write),    128'(0));
    chk("rst_mem_addr",  128'(bus.mem_addr),     128'(0));
    chk("rst_ic_ready",  128'(bus.ic_mem_ready), 128'(0));
    chk("rst_ic_cnt",    128'(ic_wait_cnt),      128'(0));
    bus.ic_mem_read = 1'b0;
    bus.mem_ready   = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Single I read, memory ready in the fourth command cycle
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h10;
    #1;
    chk("t1_c0_read", 128'(bus.mem_read), 128'(0));
    tick();
    chk("t1_c1_read", 128'(bus.mem_read), 128'(1));
    chk("t1_c1_addr", 128'(bus.mem_addr), 128'(28'h10));
    chk("t1_c1_write", 128'(bus.mem_write), 128'(0));
    tick();
    chk("t1_c2_read", 128'(bus.mem_read), 128'(1));
    tick();
    chk("t1_c3_read",  128'(bus.mem_read),     128'(1));
    chk("t1_c3_ready", 128'(bus.ic_mem_ready), 128'(0));
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hA5;
    #1;
    chk("t1_c4_read",     128'(bus.mem_read),     128'(1));
    chk("t1_c4_ic_ready", 128'(bus.ic_mem_ready), 128'(1));
    chk("t1_c4_ic_rdata", bus.ic_mem_rdata,       128'hA5);
    chk("t1_c4_dc_ready", 128'(bus.dc_mem_ready), 128'(0));
    tick();
    bus.mem_ready   = 1'b0;
    bus.ic_mem_read = 1'b0;
    #1;
    chk("t1_rel_read", 128'(bus.mem_read), 128'(0));
    chk("t1_ic_cnt",   128'(ic_wait_cnt),  128'(4));
    tick();

    // Stray mem_ready while idle: no pulse, and the arbiter still starts the next request on time
    bus.mem_ready = 1'b1;
    #1;
    chk("stray_ic_ready", 128'(bus.ic_mem_ready), 128'(0));
    chk("stray_dc_ready", 128'(bus.dc_mem_ready), 128'(0));
    tick();
    bus.mem_ready   = 1'b0;
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h30;
    #1;
    chk("stray_idle_read", 128'(bus.mem_read), 128'(0));
    tick();
    chk("stray_next_read", 128'(bus.mem_read), 128'(1));
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready   = 1'b0;
    bus.ic_mem_read = 1'b0;
    tick();

    // Both pending at reset release: D first, then I
    rst = 1'b0;
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h100;
    bus.dc_mem_read = 1'b1;
    bus.dc_mem_addr = 28'h200;
    #1;
    chk("t2_rst_ic_cnt", 128'(ic_wait_cnt), 128'(0));
    tick();
    rst = 1'b1;
    #1;
    chk("t2_c0_read", 128'(bus.mem_read), 128'(0));
    tick();
    chk("t2_c1_read", 128'(bus.mem_read), 128'(1));
    chk("t2_c1_addr", 128'(bus.mem_addr), 128'(28'h200));
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'hD1;
    #1;
    chk("t2_dc_ready", 128'(bus.dc_mem_ready), 128'(1));
    chk("t2_dc_rdata", bus.dc_mem_rdata,       128'hD1);
    chk("t2_ic_ready", 128'(bus.ic_mem_ready), 128'(0));
    tick();
    bus.mem_ready   = 1'b0;
    bus.dc_mem_read = 1'b0;
    #1;
    chk("t2_rel_read", 128'(bus.mem_read), 128'(0));
    chk("t2_dc_cnt",   128'(dc_wait_cnt),  128'(2));
    tick();
    chk("t2_idle_read", 128'(bus.mem_read), 128'(0));
    tick();
    chk("t2_i_read", 128'(bus.mem_read), 128'(1));
    chk("t2_i_addr", 128'(bus.mem_addr), 128'(28'h100));
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 128'h1C;
    #1;
    chk("t2_i_ready",  128'(bus.ic_mem_ready), 128'(1));
    chk("t2_i_rdata",  bus.ic_mem_rdata,       128'h1C);
    chk("t2_i_dc_rdy", 128'(bus.dc_mem_ready), 128'(0));
    chk("t2_ic_cnt",   128'(ic_wait_cnt),      128'(5));
    tick();
    bus.mem_ready   = 1'b0;
    bus.ic_mem_read = 1'b0;
    tick();

    // D read+write together is a write
    bus.dc_mem_read  = 1'b1;
    bus.dc_mem_write = 1'b1;
    bus.dc_mem_addr  = 28'h20;
    bus.dc_mem_wdata = 128'h1;
    tick();
    chk("t3_write", 128'(bus.mem_write), 128'(1));
    chk("t3_read",  128'(bus.mem_read),  128'(0));
    chk("t3_addr",  128'(bus.mem_addr),  128'(28'h20));
    chk("t3_wdata", bus.mem_wdata,       128'h1);
    bus.mem_ready = 1'b1;
    #1;
    chk("t3_dc_ready", 128'(bus.dc_mem_ready), 128'(1));
    tick();
    bus.mem_ready    = 1'b0;
    bus.dc_mem_read  = 1'b0;
    bus.dc_mem_write = 1'b0;
    tick();

    // Continuous contention: alternate D,I,... with two idle memory cycles between commands
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h111;
    bus.dc_mem_read = 1'b1;
    bus.dc_mem_addr = 28'h222;
    #1;
    for (int k = 0; k < 6; k++) begin
      idle = 0;
      while (!(bus.mem_read | bus.mem_write) && idle < 10) begin
        idle++;
        tick();
      end
      if (k > 0) chk($sformatf("t4_idle_%0d", k), 128'(idle), 128'(2));
      chk($sformatf("t4_addr_%0d", k), 128'(bus.mem_addr),
          (k % 2 == 0) ? 128'(28'h222) : 128'(28'h111));
      tick();
      bus.mem_ready = 1'b1;
      #1;
      chk($sformatf("t4_dc_ready_%0d", k), 128'(bus.dc_mem_ready), 128'((k % 2 == 0) ? 1 : 0));
      chk($sformatf("t4_ic_ready_%0d", k), 128'(bus.ic_mem_ready), 128'((k % 2 == 0) ? 0 : 1));
      tick();
      bus.mem_ready = 1'b0;
      #1;
    end
    bus.ic_mem_read = 1'b0;
    bus.dc_mem_read = 1'b0;
    tick(); tick();

    // Reset in the middle of a transaction abandons it at once
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h40;
    tick();
    chk("t5_busy_read", 128'(bus.mem_read), 128'(1));
    bus.mem_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_read",     128'(bus.mem_read),     128'(0));
    chk("t5_rst_write",    128'(bus.mem_write),    128'(0));
    chk("t5_rst_ic_ready", 128'(bus.ic_mem_ready), 128'(0));
    chk("t5_rst_addr",     128'(bus.mem_addr),     128'(0));
    chk("t5_rst_ic_cnt",   128'(ic_wait_cnt),      128'(0));
    chk("t5_rst_dc_cnt",   128'(dc_wait_cnt),      128'(0));
    bus.mem_ready   = 1'b0;
    bus.ic_mem_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // D stuck waiting on memory: stall counter saturates
    bus.dc_mem_read = 1'b1;
    bus.dc_mem_addr = 28'h50;
    repeat (65534) tick();
    chk("t6_cnt_fffe", 128'(dc_wait_cnt), 128'(16'hFFFE));
    tick();
    chk("t6_cnt_ffff", 128'(dc_wait_cnt), 128'(16'hFFFF));
    repeat (4465) tick();
    chk("t6_cnt_hold", 128'(dc_wait_cnt), 128'(16'hFFFF));
    chk("t6_ic_cnt",   128'(ic_wait_cnt), 128'(0));
    chk("t6_no_ready", 128'(bus.dc_mem_ready), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
